// File: rtl/cpu_pkg.sv
// cpu_pkg: shared widths, reset/vector constants and irq state encoding for the fetch stage
package cpu_pkg;
  localparam int ADDR_W = 8;
  localparam int INS_W = 20;
  localparam logic [ADDR_W-1:0] RESET_PC = 8'h00;
  localparam logic [ADDR_W-1:0] IRQ_VECTOR = 8'hF0;
  localparam logic [INS_W-1:0] NOP_INS = 20'h00000;
  typedef enum logic {RUN = 1'b0, HANDLER = 1'b1} irq_state_e;
endpackage

// File: rtl/irq_ctrl.sv
// irq_ctrl: interrupt edge detect, pending flag, RUN/HANDLER state and saved return pc
// ports: clk, reset (async high); interrupt_i pin; stall_i/branch_i/reti_i pipeline controls;
//        pc_i current pc; accept_o vector this edge; reti_o return this edge; irq_active_o; epc_o
module irq_ctrl
  import cpu_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic              interrupt_i,
  input  logic              stall_i,
  input  logic              branch_i,
  input  logic              reti_i,
  input  logic [ADDR_W-1:0] pc_i,
  output logic              accept_o,
  output logic              reti_o,
  output logic              irq_active_o,
  output logic [ADDR_W-1:0] epc_o
);
  irq_state_e state_q, state_d;
  logic irq_q, pending_q, pending_d;
  logic [ADDR_W-1:0] epc_q, epc_d;
  // branch outranks both accept and reti; accept outranks reti, so reti is only taken when no accept
  always_comb begin
    accept_o = pending_q & (state_q == RUN) & ~stall_i & ~branch_i;
    reti_o = reti_i & ~stall_i & ~branch_i & ~accept_o;
    pending_d = ~accept_o & (pending_q | (interrupt_i & ~irq_q));
    state_d = accept_o ? HANDLER : reti_o ? RUN : state_q;
    epc_d = accept_o ? pc_i : epc_q;
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= RUN;
      irq_q <= 1'b0;
      pending_q <= 1'b0;
      epc_q <= '0;
    end else begin
      state_q <= state_d;
      irq_q <= interrupt_i;
      pending_q <= pending_d;
      epc_q <= epc_d;
    end
  end
  assign irq_active_o = (state_q == HANDLER);
  assign epc_o = epc_q;
endmodule

// File: rtl/fetch_stage.sv
// fetch_stage: program counter, instruction fetch and IF/ID register with branch, stall and interrupt handling
// ports: clk, reset (async high); stall, branch_taken/branch_target, reti, interrupt controls;
//        imem_addr/imem_data ROM interface; ins/current_address/ins_valid IF/ID pair; epc, irq_active status
module fetch_stage
  import cpu_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic              stall,
  input  logic              branch_taken,
  input  logic [ADDR_W-1:0] branch_target,
  input  logic              reti,
  input  logic              interrupt,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic [INS_W-1:0]  imem_data,
  output logic [INS_W-1:0]  ins,
  output logic [ADDR_W-1:0] current_address,
  output logic              ins_valid,
  output logic [ADDR_W-1:0] epc,
  output logic              irq_active
);
  logic [ADDR_W-1:0] pc_q, pc_d, cur_q, cur_d;
  logic [INS_W-1:0] ins_q, ins_d;
  logic valid_q, valid_d, accept, reti_take, flush;
  irq_ctrl u_irq (
    .clk(clk),
    .reset(reset),
    .interrupt_i(interrupt),
    .stall_i(stall),
    .branch_i(branch_taken),
    .reti_i(reti),
    .pc_i(pc_q),
    .accept_o(accept),
    .reti_o(reti_take),
    .irq_active_o(irq_active),
    .epc_o(epc)
  );
  // any redirect discards the instruction fetched this cycle; current_address keeps its last value
  always_comb begin
    flush = branch_taken | accept | reti_take;
    pc_d = branch_taken ? branch_target : accept ? IRQ_VECTOR : reti_take ? epc : stall ? pc_q : pc_q + 1'b1;
    ins_d = flush ? NOP_INS : stall ? ins_q : imem_data;
    cur_d = (flush | stall) ? cur_q : pc_q;
    valid_d = flush ? 1'b0 : stall ? valid_q : 1'b1;
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pc_q <= RESET_PC;
      ins_q <= NOP_INS;
      cur_q <= '0;
      valid_q <= 1'b0;
    end else begin
      pc_q <= pc_d;
      ins_q <= ins_d;
      cur_q <= cur_d;
      valid_q <= valid_d;
    end
  end
  assign imem_addr = pc_q;
  assign ins = ins_q;
  assign current_address = cur_q;
  assign ins_valid = valid_q;
endmodule

// File: tb/tb_fetch_stage.sv
// tb_fetch_stage: vector table with scoreboard queue plus hand-written reset sequences for fetch_stage
module tb_fetch_stage;
  logic clk = 1'b0, reset = 1'b1, stall = 1'b0, branch_taken = 1'b0, reti = 1'b0, interrupt = 1'b0;
  logic [7:0] branch_target = '0, imem_addr, current_address, epc;
  logic [19:0] imem_data, ins;
  logic ins_valid, irq_active;
  int total = 0, passed = 0;
  typedef struct {
    logic st, br, rt, it;
    logic [7:0] tgt, pc, cur, epc;
    logic v, irq;
  } vec_t;
  vec_t vecs[$];
  vec_t sb[$];
  fetch_stage dut (
    .clk(clk), .reset(reset), .stall(stall), .branch_taken(branch_taken),
    .branch_target(branch_target), .reti(reti), .interrupt(interrupt),
    .imem_addr(imem_addr), .imem_data(imem_data), .ins(ins),
    .current_address(current_address), .ins_valid(ins_valid), .epc(epc), .irq_active(irq_active)
  );
  always #5 clk = ~clk;
  assign imem_data = 20'h10000 + {12'h0, imem_addr};
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) $display("FAIL %s: got %0h expected %0h", name, act, exp);
    else passed++;
  endtask
  task automatic add(input logic st, br, input logic [7:0] tgt, input logic rt, it,
                     input logic [7:0] pc, cur, input logic v, input logic [7:0] e, input logic irq);
    vec_t x;
    x.st = st; x.br = br; x.tgt = tgt; x.rt = rt; x.it = it;
    x.pc = pc; x.cur = cur; x.v = v; x.epc = e; x.irq = irq;
    vecs.push_back(x);
  endtask
  task automatic step(input logic st, br, input logic [7:0] tgt, input logic rt, it);
    stall = st; branch_taken = br; branch_target = tgt; reti = rt; interrupt = it;
    @(posedge clk);
    #1;
  endtask
  initial begin
    vec_t e;
    //  st br tgt   rt it   pc     cur    v  epc    irq
    add(0, 0, 8'h00, 0, 0, 8'h01, 8'h00, 1, 8'h00, 0);
    add(0, 0, 8'h00, 0, 0, 8'h02, 8'h01, 1, 8'h00, 0);
    add(0, 0, 8'h00, 0, 0, 8'h03, 8'h02, 1, 8'h00, 0);
    add(0, 0, 8'h00, 0, 0, 8'h04, 8'h03, 1, 8'h00, 0);
    add(0, 0, 8'h00, 0, 0, 8'h05, 8'h04, 1, 8'h00, 0);
    add(1, 0, 8'h00, 0, 0, 8'h05, 8'h04, 1, 8'h00, 0);
    add(1, 0, 8'h00, 0, 0, 8'h05, 8'h04, 1, 8'h00, 0);
    add(1, 0, 8'h00, 0, 0, 8'h05, 8'h04, 1, 8'h00, 0);
    add(0, 0, 8'h00, 0, 0, 8'h06, 8'h05, 1, 8'h00, 0);
    add(0, 0, 8'h00, 0, 0, 8'h07, 8'h06, 1, 8'h00, 0);
    add(0, 0, 8'h00, 0, 0, 8'h08, 8'h07, 1, 8'h00, 0);
    add(0, 1, 8'h40, 0, 0, 8'h40, 8'h07, 0, 8'h00, 0);
    add(0, 0, 8'h00, 0, 0, 8'h41, 8'h40, 1, 8'h00, 0);
    add(1, 1, 8'h08, 0, 0, 8'h08, 8'h40, 0, 8'h00, 0);
    add(0, 0, 8'h00, 0, 0, 8'h09, 8'h08, 1, 8'h00, 0);
    add(0, 1, 8'h11, 0, 0, 8'h11, 8'h08, 0, 8'h00, 0);
    add(0, 0, 8'h00, 0, 1, 8'h12, 8'h11, 1, 8'h00, 0);
    add(0, 0, 8'h00, 0, 1, 8'hF0, 8'h11, 0, 8'h12, 1);
    add(0, 0, 8'h00, 0, 0, 8'hF1, 8'hF0, 1, 8'h12, 1);
    add(0, 0, 8'h00, 0, 1, 8'hF2, 8'hF1, 1, 8'h12, 1);
    add(0, 0, 8'h00, 0, 0, 8'hF3, 8'hF2, 1, 8'h12, 1);
    add(0, 0, 8'h00, 1, 0, 8'h12, 8'hF2, 0, 8'h12, 0);
    add(0, 0, 8'h00, 0, 0, 8'hF0, 8'hF2, 0, 8'h12, 1);
    add(1, 0, 8'h00, 1, 0, 8'hF0, 8'hF2, 0, 8'h12, 1);
    add(0, 0, 8'h00, 1, 0, 8'h12, 8'hF2, 0, 8'h12, 0);
    add(0, 0, 8'h00, 0, 0, 8'h13, 8'h12, 1, 8'h12, 0);
    add(0, 0, 8'h00, 0, 1, 8'h14, 8'h13, 1, 8'h12, 0);
    add(0, 1, 8'h30, 0, 0, 8'h30, 8'h13, 0, 8'h12, 0);
    add(0, 0, 8'h00, 0, 0, 8'hF0, 8'h13, 0, 8'h30, 1);
    add(0, 1, 8'h50, 1, 0, 8'h50, 8'h13, 0, 8'h30, 1);
    add(0, 0, 8'h00, 1, 0, 8'h30, 8'h13, 0, 8'h30, 0);
    add(0, 0, 8'h00, 0, 0, 8'h31, 8'h30, 1, 8'h30, 0);
    add(0, 0, 8'h00, 0, 1, 8'h32, 8'h31, 1, 8'h30, 0);
    add(1, 0, 8'h00, 0, 1, 8'h32, 8'h31, 1, 8'h30, 0);
    add(0, 0, 8'h00, 0, 0, 8'hF0, 8'h31, 0, 8'h32, 1);
    add(0, 0, 8'h00, 1, 0, 8'h32, 8'h31, 0, 8'h32, 0);
    add(0, 1, 8'hFE, 0, 0, 8'hFE, 8'h31, 0, 8'h32, 0);
    add(0, 0, 8'h00, 0, 0, 8'hFF, 8'hFE, 1, 8'h32, 0);
    add(0, 0, 8'h00, 0, 0, 8'h00, 8'hFF, 1, 8'h32, 0);
    add(0, 0, 8'h00, 0, 0, 8'h01, 8'h00, 1, 8'h32, 0);
    #1;
    chk("reset_pc", imem_addr, 8'h00);
    chk("reset_ins", ins, 20'h0);
    chk("reset_cur", current_address, 8'h00);
    chk("reset_valid", ins_valid, 1'b0);
    chk("reset_epc", epc, 8'h00);
    chk("reset_irq", irq_active, 1'b0);
    #1 reset = 1'b0;
    foreach (vecs[i]) begin
      sb.push_back(vecs[i]);
      step(vecs[i].st, vecs[i].br, vecs[i].tgt, vecs[i].rt, vecs[i].it);
      e = sb.pop_front();
      chk($sformatf("v%0d_pc", i), imem_addr, e.pc);
      chk($sformatf("v%0d_cur", i), current_address, e.cur);
      chk($sformatf("v%0d_valid", i), ins_valid, e.v);
      chk($sformatf("v%0d_ins", i), ins, e.v ? 20'h10000 + {12'h0, e.cur} : 20'h0);
      chk($sformatf("v%0d_epc", i), epc, e.epc);
      chk($sformatf("v%0d_irq", i), irq_active, e.irq);
    end
    step(0, 0, 8'h00, 0, 1);
    step(0, 0, 8'h00, 0, 0);
    chk("pre_rst_irq", irq_active, 1'b1);
    chk("pre_rst_epc", epc, 8'h02);
    step(0, 0, 8'h00, 0, 1);
    interrupt = 1'b0;
    stall = 1'b1;
    #2 reset = 1'b1;
    #1;
    chk("async_rst_pc", imem_addr, 8'h00);
    chk("async_rst_valid", ins_valid, 1'b0);
    chk("async_rst_ins", ins, 20'h0);
    chk("async_rst_irq", irq_active, 1'b0);
    chk("async_rst_epc", epc, 8'h00);
    #1 reset = 1'b0;
    step(0, 0, 8'h00, 0, 0);
    chk("post_rst_ins0", ins, 20'h10000);
    chk("post_rst_cur0", current_address, 8'h00);
    chk("post_rst_valid0", ins_valid, 1'b1);
    step(0, 0, 8'h00, 0, 0);
    chk("post_rst_ins1", ins, 20'h10001);
    chk("post_rst_pc", imem_addr, 8'h02);
    chk("post_rst_no_irq", irq_active, 1'b0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule

// File: doc/fetch_stage.md
Name: fetch_stage

Overview:
Instruction-fetch stage of the 8-bit MIPS pipeline. It owns the program counter, drives the 20-bit instruction ROM address, and registers the IF/ID pair (ins, current_address) consumed by decode. It also absorbs the external interrupt pin, vectors to the handler, saves the return PC, and services branch redirects, stalls and return-from-interrupt.

Parameters:
ADDR_W, 8, PC / instruction-memory address width
INS_W, 20, instruction width
RESET_PC, 8'h00, PC value after reset
IRQ_VECTOR, 8'hF0, handler entry address
NOP_INS, 20'h00000, bubble instruction inserted on flush

Ports:
clk  in  1  system clock, rising edge
reset  in  1  asynchronous, active-high reset
stall  in  1  hazard unit: hold PC and the IF/ID register
branch_taken  in  1  EX: redirect fetch, flush IF/ID
branch_target  in  ADDR_W  EX: redirect address
reti  in  1  decode: return from interrupt
interrupt  in  1  external interrupt request, level, rising-edge significant
imem_addr  out  ADDR_W  ROM address, combinational = pc
imem_data  in  INS_W  ROM data, combinational, same cycle
ins  out  INS_W  IF/ID instruction
current_address  out  ADDR_W  IF/ID address of ins
ins_valid  out  1  IF/ID holds a real instruction (0 = bubble)
epc  out  ADDR_W  saved return address
irq_active  out  1  handler in progress

Behaviour:
- Reset (async, any time, including mid-stall/mid-interrupt): pc=RESET_PC, ins=NOP_INS, current_address=0, ins_valid=0, epc=0, irq_active=0, pending=0, irq_q=0. First real instruction appears on ins one edge after reset deasserts.
- Per rising edge, priority high to low:
  1. branch_taken: pc<=branch_target; ins<=NOP_INS; ins_valid<=0; current_address unchanged. Overrides stall, interrupt accept and reti.
  2. Interrupt accept (pending & ~irq_active & ~stall): epc<=pc; pc<=IRQ_VECTOR; irq_active<=1; pending<=0; IF/ID flushed (NOP, valid 0).
  3. reti & ~stall: pc<=epc; irq_active<=0; IF/ID flushed.
  4. stall: pc, ins, current_address, ins_valid all hold.
  5. Normal: ins<=imem_data; current_address<=pc; ins_valid<=1; pc<=pc+1, modulo 2^ADDR_W (8'hFF wraps to 8'h00).
- Interrupt detect: irq_q<=interrupt each edge. A rising edge (interrupt & ~irq_q) sets pending. Pending is held through stall, branch and irq_active, and is cleared only by accept or reset. Edges arriving while pending is already set merge into the one pending request. Earliest accept is the edge after the sampling edge.
- Non-nesting: while irq_active=1 no accept occurs. If pending is set during a handler, the earliest accept is the edge after the reti edge (irq_active=0). epc is then overwritten with the pc restored by reti.
- State machine (irq_ctrl): RUN (irq_active=0) to HANDLER on accept; HANDLER to RUN on reti without branch. reti while in RUN restores pc=epc and is otherwise harmless.
- Simultaneous branch and accept: branch wins, pending stays set, and accept happens next eligible edge with epc = branch_target.
- Simultaneous reti and branch: branch wins and irq_active is unchanged.

Decomposition:
- Shared package cpu_pkg: ADDR_W, INS_W, RESET_PC, IRQ_VECTOR, NOP_INS, plus the irq state encoding (RUN=0, HANDLER=1).
- One sub-module, irq_ctrl: edge detect, pending flag, RUN/HANDLER state, epc register. It outputs accept and irq_active. The PC mux and IF/ID register stay in fetch_stage.

Test Plan:
- Reset release with ROM[k]=20'h10000+k: after reset falls, successive edges give ins=20'h10000, 20'h10001…, current_address=0,1,… and ins_valid=1 from the first edge onward. Asserting reset mid-run forces pc=0 and ins_valid=0 immediately, without waiting for a clock edge.
- Stall for 3 cycles at pc=5: imem_addr stays 5, and ins/current_address hold 4's values for 3 edges. Fetch resumes at 5 with no skipped or duplicated instruction.
- Branch at pc=8 with target 8'h40: next edge gives ins=NOP_INS and ins_valid=0. The following edge gives current_address=8'h40. Repeat with stall=1 at the same edge: the branch is still taken.
- Interrupt rising edge while pc=8'h12: one edge later pending=1, and the next edge gives pc=8'hF0, epc=8'h12, irq_active=1, ins_valid=0. On reti, pc returns to 8'h12 and irq_active=0.
- Second interrupt edge during the handler: no vectoring while irq_active=1. Vectoring to 8'hF0 happens on the edge after reti, with epc equal to the restored pc.
- Wrap-around: free run from pc=8'hFE gives current_address 8'hFE, 8'hFF, 8'h00, with ins_valid=1 throughout.
